// File: rtl/commit_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// commit_sequencer_pkg
// Shared types for the commit stage: FSM states, scoreboard entry, exception.
// Revision: 1.0
// ============================================================================
package commit_sequencer_pkg;

    localparam int XLEN             = 64;
    localparam int COMMIT_MAX_PORTS = 2;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        STORE_WAIT = 2'd1,
        EXC_WAIT   = 2'd2
    } commit_state_e;

    typedef enum logic [2:0] {
        FU_NONE  = 3'd0,
        FU_ALU   = 3'd1,
        FU_LOAD  = 3'd2,
        FU_STORE = 3'd3,
        FU_CSR   = 3'd4,
        FU_FPU   = 3'd5
    } fu_t;

    typedef struct packed {
        logic [XLEN-1:0] cause;
        logic [XLEN-1:0] tval;
        logic            valid;
    } exception_t;

    typedef struct packed {
        logic            valid;
        fu_t             fu;
        logic [4:0]      rd;
        logic            rd_fp;
        logic [XLEN-1:0] result;
        exception_t      ex;
    } scoreboard_entry_t;

    // An entry that may retire alongside a neighbour in the same cycle.
    function automatic logic is_plain(input scoreboard_entry_t e);
        return !e.ex.valid && (e.fu != FU_STORE) && (e.fu != FU_CSR);
    endfunction

endpackage
`default_nettype wire

// File: rtl/commit_sequencer_if.sv
`default_nettype none
// ============================================================================
// commit_sequencer_if
// Scoreboard/regfile/LSU/controller bundle seen by the commit sequencer.
// Revision: 1.0
// ============================================================================
interface commit_sequencer_if
    import commit_sequencer_pkg::*;
#(
    parameter int NR_COMMIT_PORTS = 2,
    parameter int CNT_W           = 64
);
    logic                                  flush_i;
    logic                                  halt_i;
    scoreboard_entry_t [NR_COMMIT_PORTS-1:0] commit_instr_i;
    logic [NR_COMMIT_PORTS-1:0]            commit_ack_o;
    logic [NR_COMMIT_PORTS-1:0][4:0]       waddr_o;
    logic [NR_COMMIT_PORTS-1:0][XLEN-1:0]  wdata_o;
    logic [NR_COMMIT_PORTS-1:0]            we_gpr_o;
    logic [NR_COMMIT_PORTS-1:0]            we_fpr_o;
    logic                                  commit_lsu_o;
    logic                                  commit_lsu_ready_i;
    exception_t                            exception_o;
    logic                                  flush_commit_o;
    logic [CNT_W-1:0]                      instret_o;
    logic [CNT_W-1:0]                      stall_cnt_o;

    modport master (
        input  flush_i, halt_i, commit_instr_i, commit_lsu_ready_i,
        output commit_ack_o, waddr_o, wdata_o, we_gpr_o, we_fpr_o,
               commit_lsu_o, exception_o, flush_commit_o, instret_o, stall_cnt_o
    );

    modport slave (
        output flush_i, halt_i, commit_instr_i, commit_lsu_ready_i,
        input  commit_ack_o, waddr_o, wdata_o, we_gpr_o, we_fpr_o,
               commit_lsu_o, exception_o, flush_commit_o, instret_o, stall_cnt_o
    );
endinterface
`default_nettype wire

// File: rtl/commit_perf_counter.sv
`default_nettype none
// ============================================================================
// commit_perf_counter
// Free-running wrap-around counter advanced by a small increment each cycle.
// Revision: 1.0
// ============================================================================
module commit_perf_counter #(
    parameter int CNT_W = 64,
    parameter int INC_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [INC_W-1:0] inc,
    output logic [CNT_W-1:0] count
);
    logic [CNT_W-1:0] count_val;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_val <= '0;
        end else begin
            count_val <= count_val + {{(CNT_W-INC_W){1'b0}}, inc};
        end
    end

    assign count = count_val;
endmodule
`default_nettype wire

// File: rtl/commit_sequencer.sv
`default_nettype none
// ============================================================================
// commit_sequencer
// In-order retirement of the oldest scoreboard entries: regfile write-back,
// store commit handshake and precise exceptions.
// Optional macro COMMIT_PERF_CNT_EN: instret/stall counters (else tied to 0).
// Revision: 1.0
// ============================================================================
module commit_sequencer
    import commit_sequencer_pkg::*;
#(
    parameter int NR_COMMIT_PORTS = 2,
    parameter int CNT_W           = 64
) (
    input  logic               clk_i,
    input  logic               rst_i,
    commit_sequencer_if.master bus
);
    commit_state_e              state, state_next;
    logic                       ack0, ack1, take_exc, lsu_req;
    logic [NR_COMMIT_PORTS-1:0] ack;
    exception_t                 exc_hold;
    logic                       flush_pulse;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // Acks are combinational so the regfile sees the write in the retire cycle.
    always_comb begin
        state_next = state;
        ack0       = 1'b0;
        take_exc   = 1'b0;
        lsu_req    = 1'b0;
        if (rst_i || bus.flush_i) begin
            state_next = RUN;
        end else begin
            case (state)
                RUN: begin
                    if (bus.commit_instr_i[0].valid && !bus.halt_i) begin
                        if (bus.commit_instr_i[0].ex.valid) begin
                            ack0       = 1'b1;
                            take_exc   = 1'b1;
                            state_next = EXC_WAIT;
                        end else if (bus.commit_instr_i[0].fu == FU_STORE) begin
                            lsu_req = 1'b1;
                            if (bus.commit_lsu_ready_i) begin
                                ack0 = 1'b1;
                            end else begin
                                state_next = STORE_WAIT;
                            end
                        end else begin
                            ack0 = 1'b1;
                        end
                    end
                end
                STORE_WAIT: begin
                    lsu_req = 1'b1;
                    if (bus.commit_lsu_ready_i) begin
                        ack0       = 1'b1;
                        state_next = RUN;
                    end
                end
                EXC_WAIT: state_next = EXC_WAIT;
                default:  state_next = RUN;
            endcase
        end
    end

    generate
        if (NR_COMMIT_PORTS > 1) begin : g_dual
            logic unused_ex1;
            assign ack1 = ack0 && (state == RUN)
                        && is_plain(bus.commit_instr_i[0])
                        && bus.commit_instr_i[1].valid
                        && is_plain(bus.commit_instr_i[1]);
            assign ack  = {ack1, ack0};
            assign unused_ex1 = ^{bus.commit_instr_i[1].ex.cause, bus.commit_instr_i[1].ex.tval};
        end else begin : g_single
            assign ack1 = 1'b0;
            assign ack  = ack0;
        end

        for (genvar p = 0; p < NR_COMMIT_PORTS; p++) begin : g_wb
            logic wr;
            assign wr = ack[p] && !bus.commit_instr_i[p].ex.valid
                      && (bus.commit_instr_i[p].fu != FU_STORE);
            assign bus.waddr_o[p]  = ack[p] ? bus.commit_instr_i[p].rd : 5'd0;
            assign bus.wdata_o[p]  = ack[p] ? bus.commit_instr_i[p].result : {XLEN{1'b0}};
            assign bus.we_fpr_o[p] = wr && bus.commit_instr_i[p].rd_fp;
            assign bus.we_gpr_o[p] = wr && !bus.commit_instr_i[p].rd_fp
                                   && (bus.commit_instr_i[p].rd != 5'd0);
        end
    endgenerate

    // Exception and flush request are single-cycle pulses after the faulting ack.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            exc_hold    <= '0;
            flush_pulse <= 1'b0;
        end else begin
            exc_hold    <= take_exc ? bus.commit_instr_i[0].ex : '0;
            flush_pulse <= take_exc;
        end
    end

    assign bus.commit_ack_o   = ack;
    assign bus.commit_lsu_o   = lsu_req;
    assign bus.exception_o    = exc_hold;
    assign bus.flush_commit_o = flush_pulse;

`ifdef COMMIT_PERF_CNT_EN
    logic [1:0] instret_inc;
    logic [1:0] stall_inc;

    assign instret_inc = {1'b0, ack0 && !bus.commit_instr_i[0].ex.valid} + {1'b0, ack1};
    assign stall_inc   = {1'b0, state == STORE_WAIT};

    commit_perf_counter #(.CNT_W(CNT_W), .INC_W(2)) u_instret_cnt (
        .clk   (clk_i),
        .rst   (rst_i),
        .inc   (instret_inc),
        .count (bus.instret_o)
    );

    commit_perf_counter #(.CNT_W(CNT_W), .INC_W(2)) u_stall_cnt (
        .clk   (clk_i),
        .rst   (rst_i),
        .inc   (stall_inc),
        .count (bus.stall_cnt_o)
    );
`else
    assign bus.instret_o   = {CNT_W{1'b0}};
    assign bus.stall_cnt_o = {CNT_W{1'b0}};
`endif

endmodule
`default_nettype wire

// File: tb/tb_commit_sequencer.sv
`default_nettype none
// ============================================================================
// tb_commit_sequencer
// Directed bench for commit_sequencer with hand-computed expectations.
// Revision: 1.0
// ============================================================================
module tb_commit_sequencer;
    import commit_sequencer_pkg::*;

    localparam int NP = 2;
    localparam int CW = 64;
`ifdef COMMIT_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;
    logic [63:0] exp_instret = 64'd0;
    logic [63:0] exp_stall   = 64'd0;

    always #5 clk = ~clk;

    commit_sequencer_if #(.NR_COMMIT_PORTS(NP), .CNT_W(CW)) sif ();

    commit_sequencer #(.NR_COMMIT_PORTS(NP), .CNT_W(CW)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (sif)
    );

    task automatic chk_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic scoreboard_entry_t ent(input logic v, input fu_t fu, input logic [4:0] rd,
                                              input logic fp, input logic [63:0] res,
                                              input logic exv, input logic [63:0] cause);
        scoreboard_entry_t e;
        e          = '0;
        e.valid    = v;
        e.fu       = fu;
        e.rd       = rd;
        e.rd_fp    = fp;
        e.result   = res;
        e.ex.valid = exv;
        e.ex.cause = cause;
        return e;
    endfunction

    task automatic drive(input scoreboard_entry_t e0, input scoreboard_entry_t e1,
                         input logic halt, input logic flush, input logic ready);
        sif.commit_instr_i[0]  = e0;
        sif.commit_instr_i[1]  = e1;
        sif.halt_i             = halt;
        sif.flush_i            = flush;
        sif.commit_lsu_ready_i = ready;
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_cnt(input string tag);
        chk_val({tag, "_instret"}, sif.instret_o,   PERF ? exp_instret : 64'd0);
        chk_val({tag, "_stall"},   sif.stall_cnt_o, PERF ? exp_stall   : 64'd0);
    endtask

    scoreboard_entry_t idle, a5, a6, a8, csr7, r0, f0, st, ex2;

    initial begin
        idle = '0;
        a5   = ent(1'b1, FU_ALU,   5'd5, 1'b0, 64'h11, 1'b0, 64'd0);
        a6   = ent(1'b1, FU_ALU,   5'd6, 1'b0, 64'h22, 1'b0, 64'd0);
        a8   = ent(1'b1, FU_ALU,   5'd8, 1'b0, 64'h44, 1'b0, 64'd0);
        csr7 = ent(1'b1, FU_CSR,   5'd7, 1'b0, 64'h33, 1'b0, 64'd0);
        r0   = ent(1'b1, FU_ALU,   5'd0, 1'b0, 64'h99, 1'b0, 64'd0);
        f0   = ent(1'b1, FU_FPU,   5'd0, 1'b1, 64'h55, 1'b0, 64'd0);
        st   = ent(1'b1, FU_STORE, 5'd0, 1'b0, 64'h0,  1'b0, 64'd0);
        ex2  = ent(1'b1, FU_ALU,   5'd3, 1'b0, 64'h0,  1'b1, 64'd2);

        // Reset with valid entries presented: nothing may retire.
        rst = 1'b1;
        drive(a5, a6, 1'b0, 1'b0, 1'b0);
        nxt(); nxt();
        @(negedge clk);
        chk_val("rst_ack",   sif.commit_ack_o,       64'd0);
        chk_val("rst_we",    sif.we_gpr_o,           64'd0);
        chk_val("rst_lsu",   sif.commit_lsu_o,       64'd0);
        chk_val("rst_exc",   sif.exception_o.valid,  64'd0);
        chk_val("rst_flush", sif.flush_commit_o,     64'd0);
        chk_cnt("rst");
        nxt();
        rst = 1'b0;

        // Dual ALU retire.
        drive(a5, a6, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk_val("dual_ack",    sif.commit_ack_o, 64'd3);
        chk_val("dual_we_gpr", sif.we_gpr_o,     64'd3);
        chk_val("dual_we_fpr", sif.we_fpr_o,     64'd0);
        chk_val("dual_waddr",  sif.waddr_o,      64'h0C5);
        chk_val("dual_wdata0", sif.wdata_o[0],   64'h11);
        chk_val("dual_wdata1", sif.wdata_o[1],   64'h22);
        exp_instret += 64'd2;

        // CSR serialises: only port 0 retires.
        nxt();
        drive(csr7, a8, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk_cnt("dual");
        chk_val("csr_ack", sif.commit_ack_o, 64'd1);
        chk_val("csr_we",  sif.we_gpr_o,     64'd1);
        exp_instret += 64'd1;
        nxt();
        drive(a8, idle, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk_val("csr_next_ack",   sif.commit_ack_o, 64'd1);
        chk_val("csr_next_waddr", sif.waddr_o[0],   64'd8);
        exp_instret += 64'd1;

        // rd=0 never writes the GPR file; FP destination writes the FPR file.
        nxt();
        drive(r0, f0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk_val("rd0_ack",    sif.commit_ack_o, 64'd3);
        chk_val("rd0_we_gpr", sif.we_gpr_o,     64'd0);
        chk_val("rd0_we_fpr", sif.we_fpr_o,     64'd2);
        chk_val("rd0_wdata1", sif.wdata_o[1],   64'h55);
        exp_instret += 64'd2;

        // Halt blocks retirement for as long as it is held.
        for (int c = 0; c < 2; c++) begin
            nxt();
            drive(a5, a6, 1'b1, 1'b0, 1'b0);
            @(negedge clk);
            chk_val("halt_ack", sif.commit_ack_o, 64'd0);
            chk_val("halt_we",  sif.we_gpr_o,     64'd0);
        end
        nxt();
        drive(a5, a6, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk_cnt("halt");
        chk_val("unhalt_ack", sif.commit_ack_o, 64'd3);
        exp_instret += 64'd2;

        // Store stall: ready low three cycles (halt in the middle is ignored).
        for (int c = 0; c < 4; c++) begin
            nxt();
            drive(st, a6, (c == 1 || c == 2), 1'b0, (c == 3));
            @(negedge clk);
            chk_val("st_lsu", sif.commit_lsu_o, 64'd1);
            chk_val("st_ack", sif.commit_ack_o, (c == 3) ? 64'd1 : 64'd0);
            chk_val("st_we",  sif.we_gpr_o,     64'd0);
            if (c > 0) exp_stall += 64'd1;
        end
        exp_instret += 64'd1;
        nxt();
        drive(idle, idle, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk_val("st_done_lsu", sif.commit_lsu_o, 64'd0);
        chk_cnt("st_done");

        // Store accepted in the same cycle stays in RUN.
        nxt();
        drive(st, a6, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        chk_val("st_fast_ack", sif.commit_ack_o, 64'd1);
        chk_val("st_fast_lsu", sif.commit_lsu_o, 64'd1);
        exp_instret += 64'd1;
        nxt();
        drive(a6, idle, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk_val("st_fast_run_ack", sif.commit_ack_o, 64'd1);
        chk_val("st_fast_run_lsu", sif.commit_lsu_o, 64'd0);
        exp_instret += 64'd1;

        // Exception: ack without write, one-cycle exception/flush, then wait.
        nxt();
        drive(ex2, a6, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk_val("exc_ack",      sif.commit_ack_o,      64'd1);
        chk_val("exc_we",       sif.we_gpr_o,          64'd0);
        chk_val("exc_early",    sif.exception_o.valid, 64'd0);
        nxt();
        drive(a5, a6, 1'b0, 1'b0, 1'b0);
        chk_val("exc_valid",    sif.exception_o.valid, 64'd1);
        chk_val("exc_cause",    sif.exception_o.cause, 64'd2);
        chk_val("exc_flush",    sif.flush_commit_o,    64'd1);
        @(negedge clk);
        chk_val("exc_wait_ack", sif.commit_ack_o,      64'd0);
        nxt();
        @(negedge clk);
        chk_val("exc_pulse_valid", sif.exception_o.valid, 64'd0);
        chk_val("exc_pulse_flush", sif.flush_commit_o,    64'd0);
        chk_val("exc_wait2_ack",   sif.commit_ack_o,      64'd0);
        chk_cnt("exc");
        nxt();
        drive(a5, a6, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        chk_val("exc_flush_ack", sif.commit_ack_o, 64'd0);
        chk_val("exc_flush_we",  sif.we_gpr_o,     64'd0);
        nxt();
        drive(a5, a6, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk_val("exc_resume_ack", sif.commit_ack_o, 64'd3);
        exp_instret += 64'd2;

        // Flush while waiting for the LSU abandons the store.
        nxt();
        drive(st, idle, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk_val("fst_lsu", sif.commit_lsu_o, 64'd1);
        nxt();
        drive(st, idle, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        chk_val("fst_flush_lsu", sif.commit_lsu_o, 64'd0);
        chk_val("fst_flush_ack", sif.commit_ack_o, 64'd0);
        exp_stall += 64'd1;
        nxt();
        drive(a5, idle, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk_val("fst_run_ack", sif.commit_ack_o, 64'd1);
        chk_val("fst_run_lsu", sif.commit_lsu_o, 64'd0);
        chk_cnt("fst");

        // Reset in STORE_WAIT drops the request and clears counters.
        nxt();
        drive(st, idle, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk_val("rst_st_lsu", sif.commit_lsu_o, 64'd1);
        nxt();
        rst = 1'b1;
        @(negedge clk);
        chk_val("rst_st_hold_lsu", sif.commit_lsu_o, 64'd0);
        nxt();
        rst = 1'b0;
        drive(idle, idle, 1'b0, 1'b0, 1'b0);
        exp_instret = 64'd0;
        exp_stall   = 64'd0;
        @(negedge clk);
        chk_val("rst_st_after_lsu", sif.commit_lsu_o, 64'd0);
        chk_cnt("rst_st");
        nxt();
        drive(a5, idle, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk_val("rst_st_run_ack", sif.commit_ack_o, 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/commit_sequencer.md
Name: commit_sequencer

Overview:
- In-order retirement block on the consumer side of the issue stage's commit interface.
- Reads the oldest NR_COMMIT_PORTS scoreboard entries and acknowledges them in program order. Drives the GPR/FPR write-back ports, handshakes store commits with the LSU, and raises precise exceptions.
- Sits between the scoreboard commit outputs and the regfile, LSU and controller.

Parameters:
NR_COMMIT_PORTS, 2, commit ports; port 0 is the oldest entry; only 1 and 2 are supported.
CNT_W, 64, width of the retirement counters.

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
flush_i  in  1  controller flush; synchronous, priority below reset
halt_i  in  1  blocks new commits
commit_instr_i  in  NR_COMMIT_PORTS x scoreboard_entry_t  oldest entries from scoreboard
commit_ack_o  out  NR_COMMIT_PORTS  retire strobe per port
waddr_o  out  NR_COMMIT_PORTS x 5  regfile write address
wdata_o  out  NR_COMMIT_PORTS x XLEN  regfile write data (entry result)
we_gpr_o  out  NR_COMMIT_PORTS  GPR write enable
we_fpr_o  out  NR_COMMIT_PORTS  FPR write enable
commit_lsu_o  out  1  request to commit the store at port 0
commit_lsu_ready_i  in  1  LSU accepts the store commit
exception_o  out  exception_t  registered exception to the controller
flush_commit_o  out  1  one-cycle pulse requesting a pipeline flush
instret_o  out  CNT_W  retired-instruction count
stall_cnt_o  out  CNT_W  cycles spent in STORE_WAIT

Behaviour:
- Reset values: all outputs 0; state = RUN.
- Writes and acks are combinational with the entry, so the scoreboard never exposes stale regfile data.
  - Ack on port p implies same-cycle we = valid rd write; rd==0 never asserts we_gpr.
  - FP destination → we_fpr, else we_gpr.
- States: RUN, STORE_WAIT, EXC_WAIT.
- RUN, port 0 (entry valid, !halt_i):
  - ex.valid → ack port 0 with no write. Next cycle: exception_o = entry.ex and flush_commit_o = 1, each for exactly one cycle. Go to EXC_WAIT.
  - fu==STORE → commit_lsu_o = 1.
    - If commit_lsu_ready_i is high the same cycle: ack and stay in RUN.
    - Else go to STORE_WAIT.
  - fu==CSR → ack port 0 only; port 1 is blocked this cycle.
  - Otherwise → ack.
- RUN, port 1 acks only when all hold:
  - port 0 acks the same cycle;
  - port 0 is not an exception, CSR or store;
  - port 1 is valid, with no exception, not STORE, not CSR.
- Same rd on both ports in one cycle: both we asserted; the regfile gives port 1 priority. This block does not suppress either write.
- STORE_WAIT:
  - commit_lsu_o held high and stable; no other acks.
  - Ack port 0 in the cycle commit_lsu_ready_i = 1, then go to RUN.
  - stall_cnt_o increments every cycle spent here.
- EXC_WAIT: no acks, no writes; leave only on flush_i.
- halt_i:
  - In RUN, suppresses all acks.
  - Does not abort STORE_WAIT; an in-flight store handshake completes.
- flush_i:
  - Next state = RUN; no acks, writes or commit_lsu_o that cycle.
  - Clears a pending exception_o / flush_commit_o.
  - Counters are not cleared.
- Reset mid-STORE_WAIT: return to RUN, commit_lsu_o deasserts next cycle; the LSU must treat this as abandoned.
- instret_o: increments by popcount of non-exception acks (0..NR_COMMIT_PORTS) per cycle; wraps modulo 2^CNT_W.

Optional Feature:
- Macro COMMIT_PERF_CNT_EN.
- Defined: instret_o and stall_cnt_o are registered counters as above.
- Undefined: both outputs are tied to 0 and no counter flops are synthesised; commit behaviour is identical.

Decomposition:
- Shared package (ariane_pkg): commit_state_e (RUN, STORE_WAIT, EXC_WAIT); constant COMMIT_MAX_PORTS = 2. scoreboard_entry_t and exception_t are already there.
- One sub-module, commit_perf_counter: a CNT_W saturating-free counter with increment-amount input. Instantiated twice under COMMIT_PERF_CNT_EN.

Test Plan:
- Dual ALU retire: port0 ADD rd=5 result 0x11, port1 ADD rd=6 result 0x22, both valid → ack=2'b11; we_gpr=2'b11; waddr={6,5}; instret +2 next cycle.
- Store stall: port0 STORE, commit_lsu_ready_i low 3 cycles then high → commit_lsu_o high 4 cycles, ack in cycle 4 only; stall_cnt_o = 3; port1 never acked meanwhile.
- Exception: port0 ex.valid cause=2 → ack[0] no write; next cycle exception_o.cause=2 and flush_commit_o=1 for one cycle; no acks until flush_i, then RUN resumes.
- CSR serialisation: port0 CSR, port1 ALU → ack=2'b01; port1 entry commits on a later cycle.
- rd=0 and halt: port0 ALU rd=0 → ack with we_gpr[0]=0. Then halt_i=1 with valid entries → ack=0 until halt_i drops.
- Flush in STORE_WAIT: flush_i asserted while waiting → commit_lsu_o low the following cycle, state RUN, no ack issued.
